// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control tokens, the ctl encoding and the aligner FSM states.
package tmds_pkg;

  localparam logic [9:0] TOK_CTL00 = 10'b1101010100;
  localparam logic [9:0] TOK_CTL01 = 10'b0010101011;
  localparam logic [9:0] TOK_CTL10 = 10'b0101010100;
  localparam logic [9:0] TOK_CTL11 = 10'b1010101011;

  typedef enum logic [1:0] {
    CTL_00 = 2'b00,
    CTL_01 = 2'b01,
    CTL_10 = 2'b10,
    CTL_11 = 2'b11
  } ctl_t;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    SEARCH,
    SLIP,
    SETTLE,
    ALIGNED
  } state_t;

endpackage

// File: rtl/tmds_sym_decode.sv
// Combinational 10b->8b TMDS symbol decode with control-token detect; zero latency, no flow control.
module tmds_sym_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym_i,
  output logic       is_token_o,
  output logic [1:0] ctl_o,
  output logic [7:0] data_o
);

  logic [7:0] qp;

  always_comb begin
    is_token_o = 1'b1;
    ctl_o      = CTL_00;
    unique case (sym_i)
      TOK_CTL00: ctl_o = CTL_00;
      TOK_CTL01: ctl_o = CTL_01;
      TOK_CTL10: ctl_o = CTL_10;
      TOK_CTL11: ctl_o = CTL_11;
      default: begin
        is_token_o = 1'b0;
        ctl_o      = CTL_00;
      end
    endcase
  end

  // q[9] marks an inverted payload, q[8] selects XOR vs XNOR chaining.
  always_comb begin
    qp        = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o    = '0;
    data_o[0] = qp[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = sym_i[8] ? (qp[i] ^ qp[i-1]) : ~(qp[i] ^ qp[i-1]);
    end
  end

endmodule

// File: rtl/tmds_chan_align_decode.sv
// Per-channel TMDS word aligner (bitslip control) and decoder; 2-cycle latency, free-running, no backpressure.
// Defining TMDS_ERRCNT_EN adds align_loss_cnt, a saturating count of ALIGNED->SLIP events.
module tmds_chan_align_decode
  import tmds_pkg::*;
#(
  parameter int TIMEOUT     = 1048575,
  parameter int MIN_RUN     = 8,
  parameter int SLIP_SETTLE = 8
) (
  input  logic        pixelclk,
  input  logic        rst,
  input  logic        locked,
  input  logic [9:0]  tmds_word,
  output logic        bitslip,
  output logic        aligned,
  output logic        vde,
  output logic [1:0]  ctl,
  output logic [7:0]  data
`ifdef TMDS_ERRCNT_EN
  ,
  output logic [15:0] align_loss_cnt
`endif
);

  localparam int TMAX = (TIMEOUT > SLIP_SETTLE) ? TIMEOUT : SLIP_SETTLE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MIN_RUN + 1);

  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SLIP_SETTLE - 1);
  localparam logic [TW-1:0] TIMER_MAX   = TW'(TMAX);
  localparam logic [RW-1:0] RUN_LAST    = RW'(MIN_RUN - 1);
  localparam logic [RW-1:0] RUN_MAX     = RW'(MIN_RUN);

  logic          lock_meta_q, lock_sync_q;
  logic [9:0]    word_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic          bitslip_q, bitslip_d;
  logic          aligned_q, aligned_d;
  logic          vde_q, vde_d;
  logic [1:0]    ctl_q, ctl_d;
  logic [7:0]    data_q, data_d;

  logic          is_tok;
  logic [1:0]    tok_ctl;
  logic [7:0]    dec_byte;

  tmds_sym_decode u_dec (
    .sym_i      (word_q),
    .is_token_o (is_tok),
    .ctl_o      (tok_ctl),
    .data_o     (dec_byte)
  );

  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
  assign run_inc   = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;

  // The timer doubles as the settle counter; SLIP clears it on the way into SETTLE.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    run_d   = run_q;
    unique case (state_q)
      WAIT_LOCK: begin
        timer_d = '0;
        run_d   = '0;
        if (lock_sync_q) state_d = SEARCH;
      end
      SEARCH: begin
        timer_d = timer_inc;
        run_d   = is_tok ? run_inc : '0;
        if (is_tok && run_q >= RUN_LAST) begin
          state_d = ALIGNED;
          timer_d = '0;
        end else if (timer_q >= TIMER_LAST) begin
          state_d = SLIP;
        end
      end
      SLIP: begin
        state_d = SETTLE;
        timer_d = '0;
      end
      SETTLE: begin
        timer_d = timer_inc;
        if (timer_q >= SETTLE_LAST) begin
          state_d = SEARCH;
          timer_d = '0;
          run_d   = '0;
        end
      end
      ALIGNED: begin
        if (is_tok) begin
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
          if (timer_q >= TIMER_LAST) state_d = SLIP;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    if (!lock_sync_q) begin
      state_d = WAIT_LOCK;
      timer_d = '0;
      run_d   = '0;
    end
  end

  // Outputs key off the next state so aligned rises with the MIN_RUN-th token's output word.
  always_comb begin
    aligned_d = (state_d == ALIGNED);
    bitslip_d = (state_d == SLIP);
    vde_d     = 1'b0;
    ctl_d     = CTL_00;
    data_d    = 8'h00;
    if (aligned_d) begin
      if (is_tok) begin
        ctl_d = tok_ctl;
      end else begin
        vde_d  = 1'b1;
        ctl_d  = ctl_q;
        data_d = dec_byte;
      end
    end
  end

  always_ff @(posedge pixelclk) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      word_q      <= '0;
      state_q     <= WAIT_LOCK;
      timer_q     <= '0;
      run_q       <= '0;
      bitslip_q   <= 1'b0;
      aligned_q   <= 1'b0;
      vde_q       <= 1'b0;
      ctl_q       <= CTL_00;
      data_q      <= 8'h00;
    end else begin
      lock_meta_q <= locked;
      lock_sync_q <= lock_meta_q;
      word_q      <= tmds_word;
      state_q     <= state_d;
      timer_q     <= timer_d;
      run_q       <= run_d;
      bitslip_q   <= bitslip_d;
      aligned_q   <= aligned_d;
      vde_q       <= vde_d;
      ctl_q       <= ctl_d;
      data_q      <= data_d;
    end
  end

  assign bitslip = bitslip_q;
  assign aligned = aligned_q;
  assign vde     = vde_q;
  assign ctl     = ctl_q;
  assign data    = data_q;

`ifdef TMDS_ERRCNT_EN
  logic [15:0] loss_cnt_q;

  // Survives loss of lock on purpose; only rst clears the history.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (state_q == ALIGNED && state_d == SLIP && loss_cnt_q != 16'hFFFF) begin
      loss_cnt_q <= loss_cnt_q + 16'd1;
    end
  end

  assign align_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_chan_align_decode.sv
// Bench for tmds_chan_align_decode: model deserializer honouring bitslip, decode table, random stream vs model.
module tb_tmds_chan_align_decode;

  localparam int TO = 64;
  localparam int MR = 8;
  localparam int SS = 8;

  logic        pixelclk = 1'b0;
  logic        rst = 1'b1;
  logic        locked = 1'b1;
  logic [9:0]  tmds_word = '0;
  logic        bitslip, aligned, vde;
  logic [1:0]  ctl;
  logic [7:0]  data;
`ifdef TMDS_ERRCNT_EN
  logic [15:0] align_loss_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int off = 0;
  int slips = 0;
  logic [9:0] prev_sym = '0;
  logic [9:0] cur_sym = '0;
  logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  typedef struct {
    logic [9:0] w;
    logic       v;
    logic [1:0] c;
    logic [7:0] d;
  } vec_t;
  vec_t tbl [12];

  tmds_chan_align_decode #(.TIMEOUT(TO), .MIN_RUN(MR), .SLIP_SETTLE(SS)) dut (
    .pixelclk  (pixelclk),
    .rst       (rst),
    .locked    (locked),
    .tmds_word (tmds_word),
    .bitslip   (bitslip),
    .aligned   (aligned),
    .vde       (vde),
    .ctl       (ctl),
    .data      (data)
`ifdef TMDS_ERRCNT_EN
    ,
    .align_loss_cnt (align_loss_cnt)
`endif
  );

  always #5 pixelclk = ~pixelclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int tok_idx(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == toks[i]) return i;
    return -1;
  endfunction

  // Reference decode: un-invert, then d = q ^ (q << 1) gives the XOR chain; XNOR flips bits 7:1.
  function automatic logic [7:0] ref_dec(input logic [9:0] w);
    logic [7:0] q, d;
    q = w[9] ? (w[7:0] ^ 8'hFF) : w[7:0];
    d = q ^ {q[6:0], 1'b0};
    if (!w[8]) d = d ^ 8'hFE;
    return d;
  endfunction

  function automatic logic [9:0] rnd_data();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    while (tok_idx(w) >= 0) w = 10'($urandom_range(0, 1023));
    return w;
  endfunction

  // Serial link model: bit 0 of each symbol first; every bitslip moves the word window one bit.
  task automatic cyc(input logic [9:0] s);
    logic [19:0] v;
    prev_sym  = cur_sym;
    cur_sym   = s;
    v         = {cur_sym, prev_sym} >> (10 - off);
    tmds_word = v[9:0];
    @(posedge pixelclk);
    #1;
    if (bitslip) begin
      off = (off + 1) % 10;
      slips++;
    end
  endtask

  initial begin
    int n, first, last_p, minsp, np, since, idx;
    logic ev;
    logic [1:0] ec, hold;
    logic [7:0] ed;
    logic [9:0] s;

    tbl[0]  = '{10'b0101010100, 1'b0, 2'd2, 8'h00};
    tbl[1]  = '{10'h100,        1'b1, 2'd2, 8'h00};
    tbl[2]  = '{10'h2FF,        1'b1, 2'd2, 8'hFE};
    tbl[3]  = '{10'b1010101011, 1'b0, 2'd3, 8'h00};
    tbl[4]  = '{10'h1FF,        1'b1, 2'd3, 8'h01};
    tbl[5]  = '{10'h0FF,        1'b1, 2'd3, 8'hFF};
    tbl[6]  = '{10'h3FF,        1'b1, 2'd3, 8'h00};
    tbl[7]  = '{10'b0010101011, 1'b0, 2'd1, 8'h00};
    tbl[8]  = '{10'h155,        1'b1, 2'd1, 8'hFF};
    tbl[9]  = '{10'h055,        1'b1, 2'd1, 8'h01};
    tbl[10] = '{10'h2AA,        1'b1, 2'd1, 8'h01};
    tbl[11] = '{10'b1101010100, 1'b0, 2'd0, 8'h00};

    // Reset state, then an already-aligned ctl-00 token stream.
    rst = 1'b1; locked = 1'b1; off = 0;
    repeat (3) cyc(toks[0]);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_aligned", aligned, 0);
    chk("rst_vde", vde, 0);
    chk("rst_ctl", ctl, 0);
    chk("rst_data", data, 0);
`ifdef TMDS_ERRCNT_EN
    chk("rst_loss_cnt", align_loss_cnt, 0);
`endif
    rst = 1'b0; n = 0; slips = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      cyc(toks[0]);
      if (aligned) n = i;
    end
    // Two sync flops and the WAIT_LOCK exit come before MIN_RUN tokens are counted.
    chk("t1_align_cycle", n, 3 + MR);
    chk("t1_no_slip", slips, 0);
    chk("t1_ctl", ctl, 0);
    chk("t1_vde", vde, 0);

    // Decode table: outputs for word i are sampled after word i+1 is applied (two edges later).
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].w);
      if (i > 0) begin
        chk($sformatf("tbl%0d_vde", i - 1), vde, tbl[i-1].v);
        chk($sformatf("tbl%0d_ctl", i - 1), ctl, tbl[i-1].c);
        chk($sformatf("tbl%0d_data", i - 1), data, tbl[i-1].d);
      end
    end
    cyc(toks[0]);
    chk("tbl11_vde", vde, tbl[11].v);
    chk("tbl11_ctl", ctl, tbl[11].c);
    chk("tbl11_data", data, tbl[11].d);

    // Random aligned traffic against the reference model.
    hold = 2'd0; ev = 1'b0; ec = 2'd0; ed = 8'h00; since = 0;
    for (int k = 0; k < 300; k++) begin
      if (since >= 20 || $urandom_range(0, 3) == 0) begin
        s = toks[$urandom_range(0, 3)];
        since = 0;
      end else begin
        s = rnd_data();
        since++;
      end
      cyc(s);
      chk("rnd_vde", vde, ev);
      chk("rnd_ctl", ctl, ec);
      chk("rnd_data", data, ed);
      chk("rnd_aligned", aligned, 1);
      idx = tok_idx(s);
      if (idx >= 0) begin
        hold = 2'(idx); ev = 1'b0; ec = hold; ed = 8'h00;
      end else begin
        ev = 1'b1; ec = hold; ed = ref_dec(s);
      end
    end

    // Loss of lock while aligned, then relock.
    repeat (2) cyc(toks[3]);
    chk("pre_drop_ctl", ctl, 3);
    locked = 1'b0;
    repeat (3) cyc(toks[3]);
    chk("drop_aligned", aligned, 0);
    chk("drop_vde", vde, 0);
    chk("drop_ctl", ctl, 0);
    chk("drop_data", data, 0);
    chk("drop_bitslip", bitslip, 0);
    locked = 1'b1; n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      cyc(toks[0]);
      if (aligned) n = i;
    end
    chk("relock_cycle", n, 3 + MR);

    // Timeout while aligned: the timer first sees data one input-register cycle later.
    repeat (2) cyc(toks[3]);
    n = 0; first = 0;
    for (int i = 1; i <= 70; i++) begin
      cyc(rnd_data());
      if (i == 3) chk("to_vde", vde, 1);
      if (n == 0 && !aligned) n = i;
      if (first == 0 && bitslip) first = i;
    end
    chk("to_aligned_fall", n, TO + 1);
    chk("to_slip_cycle", first, TO + 1);
`ifdef TMDS_ERRCNT_EN
    chk("to_loss_cnt", align_loss_cnt, 1);
`endif

    // 7 tokens + 1 data word forever: never aligns, slips on a fixed period.
    rst = 1'b1; off = 0;
    repeat (2) cyc(toks[0]);
    rst = 1'b0;
`ifdef TMDS_ERRCNT_EN
    chk("alt_loss_cnt_rst", align_loss_cnt, 0);
`endif
    n = 0; np = 0; last_p = 0;
    for (int i = 1; i <= 3 + TO + 4 * (TO + SS + 1) + 5; i++) begin
      cyc((i % 8 == 0) ? 10'h100 : toks[0]);
      if (aligned) n++;
      if (bitslip) begin
        if (np == 0) chk("alt_first_slip", i, TO + 3);
        else chk("alt_slip_gap", i - last_p, TO + SS + 1);
        last_p = i; np++;
      end
    end
    chk("alt_slips", np, 5);
    chk("alt_never_aligned", n, 0);

    // Token stream rotated so exactly three slips restore the boundary.
    rst = 1'b1; off = 7;
    cyc(toks[0]);
    cyc(toks[0]);
    rst = 1'b0;
    n = 0; np = 0; last_p = 0; minsp = 1000000;
    for (int i = 1; i <= 400 && n == 0; i++) begin
      cyc(toks[0]);
      if (bitslip) begin
        if (np > 0 && i - last_p < minsp) minsp = i - last_p;
        last_p = i; np++;
      end
      if (aligned) n = i;
    end
    chk("rot_slips", np, 3);
    chk("rot_min_gap_ok", (minsp >= SS + 1), 1);
    chk("rot_aligned", (n > 0), 1);
    chk("rot_ctl", ctl, 0);

    // Reset in the middle of SETTLE: no further pulse afterwards.
    rst = 1'b1; off = 0;
    cyc(10'h100);
    rst = 1'b0; first = 0;
    for (int i = 1; i <= 100 && first == 0; i++) begin
      cyc(10'h100);
      if (bitslip) first = i;
    end
    chk("ms_slip_seen", first, TO + 3);
    repeat (3) cyc(10'h100);
    rst = 1'b1;
    cyc(10'h100);
    rst = 1'b0;
    chk("ms_rst_bitslip", bitslip, 0);
    chk("ms_rst_aligned", aligned, 0);
    np = 0;
    repeat (20) begin
      cyc(10'h100);
      if (bitslip) np++;
    end
    chk("ms_no_pulse", np, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
